line_follow_sequencer: RTL and testbench
========================================

// Module: line_follow_sequencer
// PURPOSE
//  Sequencer that produces the 2-bit direction_command consumed by the motor direction
//  controller (0=straight, 1=right, 2=left, 3=stop) from the 8-bit IR reflectance pattern.
//  Debounces classifications and runs a lost-line search/halt state machine.
//  Also arbitrates between line tracking and a manual (remote) command source.
// PARAMETERS
//  DEBOUNCE       3           consecutive matching valid samples before a command commits (>=1)
//  LOST_SAMPLES   2           consecutive all-zero valid samples that declare line lost (>=1)
//  SEARCH_CYCLES  50_000_000  clock cycles of search before halting (1 s @ 50 MHz)
//  CNT_W          26          search timer width; must hold SEARCH_CYCLES-1
// PORTS
//  clk                input   1  system clock
//  reset              input   1  synchronous reset, active high
//  enable             input   1  level; low forces IDLE
//  sensor_pattern     input   8  reflectance bits, [7]=leftmost, 1=line seen
//  sensor_valid       input   1  1-cycle strobe, sensor_pattern valid
//  manual_en          input   1  level; high selects MANUAL
//  manual_cmd         input   2  manual direction code
//  manual_valid       input   1  1-cycle strobe, manual_cmd valid
//  resume             input   1  1-cycle pulse, leave HALT
//  direction_command  output  2  registered command to the motor direction controller
//  cmd_changed        output  1  1-cycle pulse the cycle direction_command takes a new value
//  state_o            output  3  IDLE=0 TRACK=1 SEARCH=2 HALT=3 MANUAL=4
// BEHAVIOUR
//  Reset: state IDLE, direction_command=3, cmd_changed=0, last_turn=1, all counters 0.
//  Classify (comb): L=|p[7:5], C=|p[4:3], R=|p[2:0]. p==0 -> LOST.
//    Else L&R -> 3. Else L -> 2. Else R -> 1. Else (C only) -> 0.
//  State priority each cycle: !enable -> IDLE; else manual_en -> MANUAL; else per-state rules.
//  Entering IDLE, MANUAL, HALT or TRACK (from IDLE/MANUAL/HALT): command<=3, cand/cnt/lost_cnt cleared.
//  IDLE: command 3; enable high & manual_en low -> TRACK next cycle.
//  TRACK, on sensor_valid:
//    - LOST: lost_cnt++; cand/cnt untouched. lost_cnt reaching LOST_SAMPLES -> SEARCH, timer=0.
//    - non-LOST: lost_cnt=0. class==cand: cnt++ (saturate at DEBOUNCE). Else cand=class, cnt=1.
//    - Sample that brings cnt to DEBOUNCE: command<=cand on that edge (visible 1 cycle after strobe).
//    - Committed 1 or 2 also updates last_turn.
//  SEARCH: command=last_turn. Timer increments every clock.
//    - Non-LOST valid sample -> TRACK; command<=class immediately; cand=class; cnt=DEBOUNCE; lost_cnt=0.
//    - Else timer==SEARCH_CYCLES-1 -> HALT, command 3. Reacquire beats timeout in the same cycle.
//  HALT: command 3; sensor samples ignored; resume -> TRACK (command 3 until debounced).
//  MANUAL: command<=manual_cmd on manual_valid (1-cycle latency); 3 until first valid.
//    manual_en low -> TRACK. Sensors ignored; last_turn held.
//  cmd_changed=1 iff the registered direction_command differs from its previous-cycle value.
//  manual_valid outside MANUAL, and resume outside HALT, are ignored.
//  Reset mid-search/manual returns to IDLE regardless of inputs.
// TESTING (DEBOUNCE=3, LOST_SAMPLES=2, SEARCH_CYCLES=20)
//  1 reset, enable=1; valid 0x18 x3 -> cmd 3,3, then 0 one cycle after 3rd strobe; cmd_changed 1 cycle.
//  2 in TRACK cmd=0: valid 0x03,0x03,0x18,0x03,0x03,0x03 -> cmd stays 0 until 6th strobe, then 1.
//  3 cmd=2 committed (0xE0 x3); valid 0x00 x2 -> state 2, cmd 2; no sample 20 clk -> state 3, cmd 3.
//  4 SEARCH: valid 0x18 on timer==19 -> state 1, cmd 0 next cycle, no HALT; resume in HALT -> TRACK, cmd 3.
//  5 TRACK cmd=0; manual_en=1 -> state 4, cmd 3; manual_valid cmd=2 -> cmd 2 next cycle;
//    sensor 0x03 strobes ignored; manual_en=0 -> TRACK, cmd 3.
//  6 valid 0x81 x3 -> cmd 3 (L&R). enable=0 mid-SEARCH -> IDLE, cmd 3.
//    reset=1 mid-MANUAL -> all reset values.

Source files
------------

// File: rtl/line_follow_sequencer.sv
// Purpose: turns debounced IR line classifications or manual commands into a motor direction code.
// Latency: a committed command appears on direction_command one cycle after the deciding strobe.
// Backpressure: none; strobes are consumed the cycle they arrive and ignored in states that do not use them.
module line_follow_sequencer #(
   parameter int DEBOUNCE      = 3,
   parameter int LOST_SAMPLES  = 2,
   parameter int SEARCH_CYCLES = 50_000_000,
   parameter int CNT_W         = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] sensor_pattern,
   input  logic       sensor_valid,
   input  logic       manual_en,
   input  logic [1:0] manual_cmd,
   input  logic       manual_valid,
   input  logic       resume,
   output logic [1:0] direction_command,
   output logic       cmd_changed,
   output logic [2:0] state_o
);

   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int LW = $clog2(LOST_SAMPLES + 1);
   localparam logic [DW-1:0]    DEB_MAX    = DW'(DEBOUNCE);
   localparam logic [DW-1:0]    DEB_ONE    = DW'(1);
   localparam logic [LW-1:0]    LOST_MAX   = LW'(LOST_SAMPLES);
   localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(SEARCH_CYCLES - 1);
   localparam logic [1:0]       CMD_STOP   = 2'd3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TRACK  = 3'd1,
      SEARCH = 3'd2,
      HALT   = 3'd3,
      MANUAL = 3'd4
   } state_t;

   state_t           state;
   logic [1:0]       last_turn;
   logic [1:0]       cand;
   logic [DW-1:0]    cnt;
   logic [LW-1:0]    lost_cnt;
   logic [CNT_W-1:0] timer;
   logic [1:0]       prev_command;

   logic             left_seen;
   logic             right_seen;
   logic             lost;
   logic [1:0]       cls;
   logic [DW-1:0]    cnt_inc;
   logic [LW-1:0]    lost_inc;
   logic             commit_now;

   assign state_o     = state;
   assign cnt_inc     = cnt + 1'b1;
   assign lost_inc    = lost_cnt + 1'b1;
   assign cmd_changed = (direction_command != prev_command);

   // Classify the pattern: both edges -> stop, one edge -> turn toward it, centre only -> straight.
   always_comb begin
      left_seen  = |sensor_pattern[7:5];
      right_seen = |sensor_pattern[2:0];
      lost       = (sensor_pattern == 8'h00);
      if (left_seen && right_seen) begin
         cls = 2'd3;
      end else if (left_seen) begin
         cls = 2'd2;
      end else if (right_seen) begin
         cls = 2'd1;
      end else begin
         cls = 2'd0;
      end
   end

   // A tracked sample commits when it is the one that lifts the matching run to DEBOUNCE;
   // the committed value is always the current class (it equals cand on a match).
   always_comb begin
      commit_now = 1'b0;
      if (state == TRACK && sensor_valid && !lost) begin
         if (cls == cand) begin
            commit_now = (cnt != DEB_MAX) && (cnt_inc == DEB_MAX);
         end else begin
            commit_now = (DEB_MAX == DEB_ONE);
         end
      end
   end

   // Main sequencer: enable and manual override take priority over the per-state rules.
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         direction_command <= CMD_STOP;
         last_turn         <= 2'd1;
         cand              <= '0;
         cnt               <= '0;
         lost_cnt          <= '0;
         timer             <= '0;
      end else if (!enable) begin
         state             <= IDLE;
         direction_command <= CMD_STOP;
         cand              <= '0;
         cnt               <= '0;
         lost_cnt          <= '0;
      end else if (manual_en) begin
         if (state != MANUAL) begin
            state             <= MANUAL;
            direction_command <= CMD_STOP;
            cand              <= '0;
            cnt               <= '0;
            lost_cnt          <= '0;
         end else if (manual_valid) begin
            direction_command <= manual_cmd;
         end
      end else begin
         case (state)
            IDLE, MANUAL: begin
               state             <= TRACK;
               direction_command <= CMD_STOP;
               cand              <= '0;
               cnt               <= '0;
               lost_cnt          <= '0;
            end
            HALT: begin
               if (resume) begin
                  state             <= TRACK;
                  direction_command <= CMD_STOP;
                  cand              <= '0;
                  cnt               <= '0;
                  lost_cnt          <= '0;
               end
            end
            TRACK: begin
               if (sensor_valid) begin
                  if (lost) begin
                     // Lost samples do not disturb the debounce run in progress.
                     lost_cnt <= lost_inc;
                     if (lost_inc == LOST_MAX) begin
                        state             <= SEARCH;
                        timer             <= '0;
                        direction_command <= last_turn;
                     end
                  end else begin
                     lost_cnt <= '0;
                     if (cls == cand) begin
                        if (cnt != DEB_MAX) begin
                           cnt <= cnt_inc;
                        end
                     end else begin
                        cand <= cls;
                        cnt  <= DEB_ONE;
                     end
                     if (commit_now) begin
                        direction_command <= cls;
                        if (cls == 2'd1 || cls == 2'd2) begin
                           last_turn <= cls;
                        end
                     end
                  end
               end
            end
            SEARCH: begin
               timer <= timer + 1'b1;
               // Reacquiring the line wins over a timeout landing on the same cycle.
               if (sensor_valid && !lost) begin
                  state             <= TRACK;
                  direction_command <= cls;
                  cand              <= cls;
                  cnt               <= DEB_MAX;
                  lost_cnt          <= '0;
                  if (cls == 2'd1 || cls == 2'd2) begin
                     last_turn <= cls;
                  end
               end else if (timer == TIMER_LAST) begin
                  state             <= HALT;
                  direction_command <= CMD_STOP;
                  cand              <= '0;
                  cnt               <= '0;
                  lost_cnt          <= '0;
               end
            end
            default: begin
               state             <= IDLE;
               direction_command <= CMD_STOP;
               cand              <= '0;
               cnt               <= '0;
               lost_cnt          <= '0;
            end
         endcase
      end
   end

   // Previous-cycle command, so cmd_changed flags exactly the cycles carrying a new value.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_command <= CMD_STOP;
      end else begin
         prev_command <= direction_command;
      end
   end

endmodule

// File: tb/tb_line_follow_sequencer.sv
// Purpose: self-checking bench for line_follow_sequencer (vector table, corner sequences, random vs model).
// Latency: outputs are checked 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives every input every cycle.
module tb_line_follow_sequencer;

   localparam int DEB   = 3;
   localparam int LOSTN = 2;
   localparam int SCYC  = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] sensor_pattern = 8'h00;
   logic       sensor_valid = 1'b0;
   logic       manual_en = 1'b0;
   logic [1:0] manual_cmd = 2'd0;
   logic       manual_valid = 1'b0;
   logic       resume = 1'b0;
   logic [1:0] direction_command;
   logic       cmd_changed;
   logic [2:0] state_o;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state (states: 0 idle, 1 track, 2 search, 3 halt, 4 manual).
   int m_state = 0, m_cmd = 3, m_prev = 3, m_last = 1;
   int m_cls = 0, m_run = 0, m_lost = 0, m_age = 0;

   always #5 clk = ~clk;

   line_follow_sequencer #(
      .DEBOUNCE(DEB), .LOST_SAMPLES(LOSTN), .SEARCH_CYCLES(SCYC), .CNT_W(5)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .sensor_pattern(sensor_pattern), .sensor_valid(sensor_valid),
      .manual_en(manual_en), .manual_cmd(manual_cmd), .manual_valid(manual_valid),
      .resume(resume), .direction_command(direction_command),
      .cmd_changed(cmd_changed), .state_o(state_o)
   );

   typedef struct packed {
      logic       rst;
      logic       en;
      logic [7:0] pat;
      logic       sv;
      logic       me;
      logic [1:0] mc;
      logic       mv;
      logic       rs;
      logic [1:0] ecmd;
      logic       echg;
      logic [2:0] est;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mkv(input logic rst, input logic en, input logic [7:0] pat,
                                input logic sv, input logic me, input logic [1:0] mc,
                                input logic mv, input logic rs, input logic [1:0] ecmd,
                                input logic echg, input logic [2:0] est);
      vec_t v;
      v.rst = rst; v.en = en; v.pat = pat; v.sv = sv; v.me = me; v.mc = mc;
      v.mv = mv; v.rs = rs; v.ecmd = ecmd; v.echg = echg; v.est = est;
      return v;
   endfunction

   // Line position from reflectance: -1 lost, 3 both edges, 2 left, 1 right, 0 centre.
   function automatic int classify(input int p);
      bit l, r;
      if (p == 0) return -1;
      l = (p / 32) != 0;
      r = (p % 8) != 0;
      if (l && r) return 3;
      if (l) return 2;
      if (r) return 1;
      return 0;
   endfunction

   task automatic model_enter(input int s);
      m_state = s;
      m_cmd   = 3;
      m_run   = 0;
      m_lost  = 0;
   endtask

   task automatic model_step();
      int c;
      m_prev = m_cmd;
      if (reset) begin
         m_state = 0; m_cmd = 3; m_prev = 3; m_last = 1;
         m_cls = 0; m_run = 0; m_lost = 0; m_age = 0;
      end else if (!enable) begin
         model_enter(0);
      end else if (manual_en) begin
         if (m_state != 4) model_enter(4);
         else if (manual_valid) m_cmd = int'(manual_cmd);
      end else begin
         case (m_state)
            0, 4: model_enter(1);
            3: if (resume) model_enter(1);
            1: if (sensor_valid) begin
               c = classify(int'(sensor_pattern));
               if (c < 0) begin
                  m_lost++;
                  if (m_lost == LOSTN) begin
                     m_state = 2; m_age = 0; m_cmd = m_last;
                  end
               end else begin
                  m_lost = 0;
                  if (m_run > 0 && c == m_cls) m_run++;
                  else begin m_cls = c; m_run = 1; end
                  if (m_run == DEB) begin
                     m_cmd = c;
                     if (c == 1 || c == 2) m_last = c;
                  end
               end
            end
            2: begin
               c = sensor_valid ? classify(int'(sensor_pattern)) : -1;
               if (c >= 0) begin
                  m_state = 1; m_cmd = c; m_cls = c; m_run = DEB; m_lost = 0;
                  if (c == 1 || c == 2) m_last = c;
               end else if (m_age == SCYC - 1) begin
                  model_enter(3);
               end else begin
                  m_age++;
               end
            end
            default: model_enter(0);
         endcase
      end
   endtask

   task automatic go(input logic rst, input logic en, input logic [7:0] pat, input logic sv,
                     input logic me, input logic [1:0] mc, input logic mv, input logic rs);
      reset = rst; enable = en; sensor_pattern = pat; sensor_valid = sv;
      manual_en = me; manual_cmd = mc; manual_valid = mv; resume = rs;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic sense(input logic [7:0] p);
      go(1'b0, 1'b1, p, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      go(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string nm, input int ecmd, input int echg, input int est);
      n_vec++;
      if ({direction_command, cmd_changed, state_o} !== {2'(ecmd), 1'(echg), 3'(est)}) begin
         n_bad++;
         $display("FAIL %s: got cmd=%0d chg=%0d state=%0d, want cmd=%0d chg=%0d state=%0d",
                  nm, direction_command, cmd_changed, state_o, ecmd, echg, est);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic       me_lvl;
      int         dark_left;
      logic [7:0] cur_pat;
      logic [7:0] picks [8];

      // rst en pat sv me mc mv rs | cmd chg state
      tbl.push_back(mkv(1,0,8'h00,0,0,0,0,0, 3,0,0));
      tbl.push_back(mkv(0,1,8'h00,0,0,0,0,0, 3,0,1));
      tbl.push_back(mkv(0,1,8'h18,1,0,0,0,0, 3,0,1));
      tbl.push_back(mkv(0,1,8'h18,1,0,0,0,0, 3,0,1));
      tbl.push_back(mkv(0,1,8'h18,1,0,0,0,0, 0,1,1));
      tbl.push_back(mkv(0,1,8'h00,0,0,0,0,0, 0,0,1));
      tbl.push_back(mkv(0,1,8'h03,1,0,0,0,0, 0,0,1));
      tbl.push_back(mkv(0,1,8'h03,1,0,0,0,0, 0,0,1));
      tbl.push_back(mkv(0,1,8'h18,1,0,0,0,0, 0,0,1));
      tbl.push_back(mkv(0,1,8'h03,1,0,0,0,0, 0,0,1));
      tbl.push_back(mkv(0,1,8'h03,1,0,0,0,0, 0,0,1));
      tbl.push_back(mkv(0,1,8'h03,1,0,0,0,0, 1,1,1));
      tbl.push_back(mkv(0,1,8'h00,0,0,0,0,0, 1,0,1));
      tbl.push_back(mkv(0,1,8'h18,1,0,0,0,0, 1,0,1));
      tbl.push_back(mkv(0,1,8'h18,1,0,0,0,0, 1,0,1));
      tbl.push_back(mkv(0,1,8'h18,1,0,0,0,0, 0,1,1));
      tbl.push_back(mkv(0,1,8'h00,0,1,0,0,0, 3,1,4));
      tbl.push_back(mkv(0,1,8'h00,0,1,2,1,0, 2,1,4));
      tbl.push_back(mkv(0,1,8'h03,1,1,0,0,0, 2,0,4));
      tbl.push_back(mkv(0,1,8'h03,1,1,0,0,0, 2,0,4));
      tbl.push_back(mkv(0,1,8'h00,0,1,0,1,0, 0,1,4));
      tbl.push_back(mkv(0,1,8'h00,0,0,0,0,0, 3,1,1));
      tbl.push_back(mkv(0,1,8'h81,1,0,0,0,0, 3,0,1));
      tbl.push_back(mkv(0,1,8'h81,1,0,0,0,0, 3,0,1));
      tbl.push_back(mkv(0,1,8'h81,1,0,0,0,0, 3,0,1));
      tbl.push_back(mkv(0,1,8'h00,0,0,0,0,1, 3,0,1));
      tbl.push_back(mkv(0,1,8'h00,0,1,0,0,0, 3,0,4));
      tbl.push_back(mkv(0,1,8'h00,0,1,1,1,0, 1,1,4));
      tbl.push_back(mkv(1,1,8'h00,0,1,0,0,0, 3,0,0));
      tbl.push_back(mkv(1,1,8'h00,0,1,0,0,0, 3,0,0));
      tbl.push_back(mkv(0,1,8'h00,0,1,0,0,0, 3,0,4));
      tbl.push_back(mkv(0,1,8'h00,0,0,0,0,0, 3,0,1));
      tbl.push_back(mkv(0,0,8'h00,0,0,0,0,0, 3,0,0));
      tbl.push_back(mkv(0,1,8'h00,0,0,0,0,0, 3,0,1));
      tbl.push_back(mkv(0,1,8'h00,0,0,2,1,0, 3,0,1));
      tbl.push_back(mkv(0,1,8'h00,1,0,0,0,0, 3,0,1));
      tbl.push_back(mkv(0,1,8'h00,1,0,0,0,0, 1,1,2));
      tbl.push_back(mkv(0,0,8'h00,0,0,0,0,0, 3,1,0));

      foreach (tbl[i]) begin
         go(tbl[i].rst, tbl[i].en, tbl[i].pat, tbl[i].sv, tbl[i].me, tbl[i].mc, tbl[i].mv, tbl[i].rs);
         chk($sformatf("vec%0d", i), int'(tbl[i].ecmd), int'(tbl[i].echg), int'(tbl[i].est));
      end

      // Lost line -> search with last turn -> timeout halt -> resume.
      go(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("seq_reset", 3, 0, 0);
      tick();
      chk("seq_track", 3, 0, 1);
      sense(8'hE0); sense(8'hE0); sense(8'hE0);
      chk("seq_left_commit", 2, 1, 1);
      sense(8'h00);
      chk("seq_lost1", 2, 0, 1);
      sense(8'h00);
      chk("seq_search_enter", 2, 0, 2);
      for (int i = 0; i < SCYC - 1; i++) begin
         tick();
         chk($sformatf("seq_search_wait%0d", i), 2, 0, 2);
      end
      tick();
      chk("seq_halt", 3, 1, 3);
      sense(8'h18);
      chk("seq_halt_ignores_sensor", 3, 0, 3);
      go(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      chk("seq_resume", 3, 0, 1);
      sense(8'h00); sense(8'h18); sense(8'h00);
      chk("seq_lost_run_broken", 3, 0, 1);
      sense(8'h00);
      chk("seq_search_last_left", 2, 1, 2);

      // Reacquire on the very cycle the timer would expire.
      for (int i = 0; i < SCYC - 1; i++) tick();
      chk("seq_search_before_expiry", 2, 0, 2);
      sense(8'h18);
      chk("seq_reacquire_at_expiry", 0, 1, 1);
      tick();
      chk("seq_no_halt_after", 0, 0, 1);
      sense(8'h18);
      chk("seq_debounced_hold", 0, 0, 1);

      // Randomized traffic against the reference model.
      picks[0] = 8'h18; picks[1] = 8'h10; picks[2] = 8'h03; picks[3] = 8'h01;
      picks[4] = 8'hE0; picks[5] = 8'h80; picks[6] = 8'h81; picks[7] = 8'h00;
      me_lvl = 1'b0;
      dark_left = 0;
      cur_pat = 8'h18;
      go(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("rand_reset", m_cmd, int'(m_cmd != m_prev), m_state);
      for (int n = 0; n < 3000; n++) begin
         logic r, e, sv, mv, rs;
         logic [1:0] mc;
         r  = ($urandom_range(0, 299) == 0);
         e  = ($urandom_range(0, 99) != 0);
         sv = ($urandom_range(0, 2) == 0);
         mv = ($urandom_range(0, 5) == 0);
         rs = ($urandom_range(0, 9) == 0);
         mc = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 79) == 0) me_lvl = ~me_lvl;
         if (dark_left > 0) dark_left--;
         else if ($urandom_range(0, 59) == 0) dark_left = int'($urandom_range(5, 60));
         if (sv && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 3) == 0) cur_pat = 8'($urandom_range(0, 255));
            else cur_pat = picks[$urandom_range(0, 7)];
         end
         go(r, e, (dark_left > 0) ? 8'h00 : cur_pat, sv, me_lvl, mc, mv, rs);
         chk($sformatf("rand%0d", n), m_cmd, int'(m_cmd != m_prev), m_state);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
